// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a hold-time limit. Each master requests on its
// arbSend line and is told GRANT/REVOKE by a 3-bit serial message (start bit 1,
// then a 2-bit code MSB-first) on its own arbCont line.
module bus_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int MAX_HOLD     = 64,
  parameter int RELEASE_WAIT = 16
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic [NUM_MASTERS-1:0]         arbSend,
  output logic [NUM_MASTERS-1:0]         arbCont,
  output logic [$clog2(NUM_MASTERS)-1:0] busSel,
  output logic                           busValid,
  output logic                           timeoutErr
);

  localparam int SEL_W  = $clog2(NUM_MASTERS);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int REL_W  = (RELEASE_WAIT > 1) ? $clog2(RELEASE_WAIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_OWNED,
    ST_REVOKE,
    ST_WAIT_REL
  } state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [REL_W-1:0]    rel_reg, rel_next;
  logic [1:0]          bit_reg, bit_next;
  logic                drop_reg, drop_next;
  logic                timeout_reg, timeout_next;

  logic [SEL_W-1:0]       winner;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] others;
  logic                   owner_req;
  logic                   msg_active;
  logic                   msg_bit;
  int                     idx_c;

  // Pick the first requester at or after the pointer; scanning offsets from
  // highest to lowest lets the nearest one overwrite the rest.
  always_comb begin
    winner  = ptr_reg;
    any_req = 1'b0;
    idx_c   = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx_c = (int'(ptr_reg) + i) % NUM_MASTERS;
      if (arbSend[idx_c]) begin
        winner  = SEL_W'(idx_c);
        any_req = 1'b1;
      end
    end
  end

  // Requests from everyone except the current holder.
  always_comb begin
    others          = arbSend;
    others[sel_reg] = 1'b0;
  end

  assign owner_req = arbSend[sel_reg];

  // Next-state logic for the arbitration FSM and its counters.
  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    rel_next     = rel_reg;
    bit_next     = bit_reg;
    drop_next    = drop_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          sel_next   = winner;
          ptr_next   = (winner == SEL_W'(NUM_MASTERS - 1)) ? '0 : winner + SEL_W'(1);
          bit_next   = 2'd0;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The message always completes; a dropped request is noticed in OWNED.
        if (bit_reg == 2'd2) begin
          hold_next  = '0;
          state_next = ST_OWNED;
        end else begin
          bit_next = bit_reg + 2'd1;
        end
      end
      ST_OWNED: begin
        if (hold_reg != HOLD_W'(MAX_HOLD)) hold_next = hold_reg + HOLD_W'(1);
        if (!owner_req) begin
          state_next = ST_IDLE;
        end else if (hold_reg == HOLD_W'(MAX_HOLD) && |others) begin
          bit_next   = 2'd0;
          drop_next  = 1'b0;
          state_next = ST_REVOKE;
        end
      end
      ST_REVOKE: begin
        // Remember any drop during the message so release is immediate after it.
        drop_next = drop_reg | ~owner_req;
        if (bit_reg == 2'd2) begin
          if (drop_next) begin
            state_next = ST_IDLE;
          end else begin
            rel_next   = '0;
            state_next = ST_WAIT_REL;
          end
        end else begin
          bit_next = bit_reg + 2'd1;
        end
      end
      ST_WAIT_REL: begin
        if (!owner_req) begin
          state_next = ST_IDLE;
        end else if (rel_reg == REL_W'(RELEASE_WAIT - 1)) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          rel_next = rel_reg + REL_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and counter registers; reset wins over everything, including mid-message.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      ptr_reg     <= '0;
      hold_reg    <= '0;
      rel_reg     <= '0;
      bit_reg     <= 2'd0;
      drop_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      rel_reg     <= rel_next;
      bit_reg     <= bit_next;
      drop_reg    <= drop_next;
      timeout_reg <= timeout_next;
    end
  end

  // Message bit: start 1, code MSB, code LSB 1; only REVOKE's middle bit is 0.
  assign msg_active = (state_reg == ST_GRANT) || (state_reg == ST_REVOKE);
  assign msg_bit    = !((state_reg == ST_REVOKE) && (bit_reg == 2'd1));

  // Only the addressed master's control line carries the message.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cont
    assign arbCont[gi] = msg_active && (sel_reg == SEL_W'(gi)) && msg_bit;
  end

  assign busSel     = sel_reg;
  assign busValid   = (state_reg == ST_OWNED) || (state_reg == ST_REVOKE) ||
                      (state_reg == ST_WAIT_REL);
  assign timeoutErr = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with NUM_MASTERS=2, MAX_HOLD=8, RELEASE_WAIT=4.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic [1:0] arbSend;
  logic [1:0] arbCont;
  logic       busSel;
  logic       busValid;
  logic       timeoutErr;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(8), .RELEASE_WAIT(4)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .arbSend    (arbSend),
    .arbCont    (arbCont),
    .busSel     (busSel),
    .busValid   (busValid),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of all outputs against expected values.
  task automatic chk_all(input string tag, input logic [1:0] cont, input logic sel,
                         input logic valid, input logic tout);
    chk({tag, ".arbCont"}, 32'(arbCont), 32'(cont));
    chk({tag, ".busSel"}, 32'(busSel), 32'(sel));
    chk({tag, ".busValid"}, 32'(busValid), 32'(valid));
    chk({tag, ".timeoutErr"}, 32'(timeoutErr), 32'(tout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN    = 1'b0;
    arbSend = 2'b00;
    step();
    step();
    rstN = 1'b1;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);

    // 1: reset in the middle of a GRANT message
    arbSend = 2'b01;
    step();
    chk_all("t1_bit1", 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("t1_bit2", 2'b01, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    step();
    chk_all("t1_after_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;

    // 3: simultaneous requests after reset -> master 0 first, then master 1
    arbSend = 2'b11;
    for (int j = 0; j < 3; j++) begin
      step();
      chk_all($sformatf("t3_grant0_bit%0d", j + 1), 2'b01, 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_all("t3_owned0", 2'b00, 1'b0, 1'b1, 1'b0);
    arbSend = 2'b10;
    step();
    chk_all("t3_release0", 2'b00, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk_all($sformatf("t3_grant1_bit%0d", j + 1), 2'b10, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("t3_owned1", 2'b00, 1'b1, 1'b1, 1'b0);
    arbSend = 2'b00;
    step();
    chk_all("t3_release1_sel_held", 2'b00, 1'b1, 1'b0, 1'b0);
    step();

    // 2: lone request from master 1
    arbSend = 2'b10;
    for (int j = 0; j < 3; j++) begin
      step();
      chk_all($sformatf("t2_grant_bit%0d", j + 1), 2'b10, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("t2_owned", 2'b00, 1'b1, 1'b1, 1'b0);
    arbSend = 2'b00;
    step();
    chk_all("t2_release", 2'b00, 1'b1, 1'b0, 1'b0);

    // 4: hold limit reached, holder drops during WAIT_REL -> no timeout
    arbSend = 2'b01;
    for (int j = 0; j < 3; j++) begin
      step();
      chk_all($sformatf("t4_grant_bit%0d", j + 1), 2'b01, 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_all("t4_owned", 2'b00, 1'b0, 1'b1, 1'b0);
    arbSend = 2'b11;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk_all($sformatf("t4_hold%0d", j), 2'b00, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_all("t4_revoke_bit1", 2'b01, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t4_revoke_bit2", 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t4_revoke_bit3", 2'b01, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t4_wait0", 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t4_wait1", 2'b00, 1'b0, 1'b1, 1'b0);
    arbSend = 2'b10;
    step();
    chk_all("t4_release", 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("t4_grant1", 2'b10, 1'b1, 1'b0, 1'b0);
    arbSend = 2'b00;
    for (int j = 0; j < 6; j++) step();
    chk_all("t4_settled", 2'b00, 1'b1, 1'b0, 1'b0);

    // 5: holder never drops -> forced release with timeout pulse
    arbSend = 2'b01;
    for (int j = 0; j < 4; j++) step();
    chk_all("t5_owned", 2'b00, 1'b0, 1'b1, 1'b0);
    arbSend = 2'b11;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk_all($sformatf("t5_hold%0d", j), 2'b00, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_all("t5_revoke_bit1", 2'b01, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t5_revoke_bit2", 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t5_revoke_bit3", 2'b01, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk_all($sformatf("t5_wait%0d", j), 2'b00, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_all("t5_timeout", 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("t5_grant1", 2'b10, 1'b1, 1'b0, 1'b0);
    arbSend = 2'b00;
    for (int j = 0; j < 6; j++) step();
    chk_all("t5_settled", 2'b00, 1'b1, 1'b0, 1'b0);

    // 6: lone holder is never revoked
    arbSend = 2'b01;
    for (int j = 0; j < 4; j++) step();
    for (int j = 0; j < 100; j++) begin
      chk_all($sformatf("t6_hold%0d", j), 2'b00, 1'b0, 1'b1, 1'b0);
      step();
    end
    arbSend = 2'b00;
    step();
    chk_all("t6_release", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
